ws2812_stream: RTL and testbench



---
 rtl/ws2812_pkg.sv | 31 +++
 rtl/ws2812_fifo.sv | 68 ++++++
 rtl/ws2812_stream.sv | 201 ++++++++++++++++++++
 tb/tb_ws2812_stream.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 strip streamer:
//   - seq_state_t : sequencer states (RST_LOW, IDLE, SEND)
//   - cyc()       : nanoseconds -> clock cycles, integer math
//   - cyc_us()    : microseconds -> clock cycles, integer math
//   - bpp_legal() : pixel width sanity check (24 or 32 bits)
// ----------------------------------------------------------------------------
package ws2812_pkg;

    typedef enum logic [1:0] {
        RST_LOW = 2'd0,
        IDLE    = 2'd1,
        SEND    = 2'd2
    } seq_state_t;

    // Cycles per x_ns, rounded down. CLK_HZ is a whole number of MHz, so
    // dividing first keeps the intermediate product well inside 32 bits.
    function automatic int cyc(input int clk_hz, input int x_ns);
        return ((clk_hz / 1000000) * x_ns) / 1000;
    endfunction

    function automatic int cyc_us(input int clk_hz, input int x_us);
        return (clk_hz / 1000000) * x_us;
    endfunction

    function automatic bit bpp_legal(input int bpp);
        return (bpp == 24) || (bpp == 32);
    endfunction

endpackage

// File: rtl/ws2812_fifo.sv
// ----------------------------------------------------------------------------
// ws2812_fifo
// Small synchronous FIFO holding {latch, pixel} entries for the streamer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (flushes the FIFO)
//   push        : write push_data this cycle (caller guarantees not full)
//   push_data   : WIDTH-bit entry to write
//   pop         : drop the head entry this cycle (caller guarantees not empty)
//   pop_data    : head entry, valid whenever empty is low
//   level       : current occupancy, 0..DEPTH
//   empty, full : occupancy flags
// ----------------------------------------------------------------------------
module ws2812_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
    // push and pop moves both pointers and leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: a flush only has to clear the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (level == '0);
    assign full     = (level == LVL_FULL);

endmodule

// File: rtl/ws2812_stream.sv
// ----------------------------------------------------------------------------
// ws2812_stream
// Streams pixels from a small FIFO onto one WS2812-family LED strip. Pixels
// go out MSB first, back to back; a pixel tagged with latch_in is followed by
// the strip reset/latch low period.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   data_in     : BPP-bit pixel, MSB sent first
//   latch_in    : end of frame marker travelling with data_in
//   valid       : producer strobe; a push happens on valid && ready
//   ready       : FIFO can take a pixel this cycle
//   level       : FIFO occupancy
//   busy        : sequencer active or pixels still queued
//   frame_done  : 1-cycle pulse when a latch low period completes
//   starved     : 1-cycle pulse when a pixel ends with nothing queued and no
//                 latch pending
//   led         : serial data to the strip
// ----------------------------------------------------------------------------
module ws2812_stream
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ     = 20000000,
    parameter int BPP        = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD_NS  = 1250,
    parameter int T0H_NS     = 400,
    parameter int T1H_NS     = 800,
    parameter int RES_US     = 300
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BPP-1:0]                data_in,
    input  logic                          latch_in,
    input  logic                          valid,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          starved,
    output logic                          led
);

    localparam int CYC_PER = cyc(CLK_HZ, PERIOD_NS);
    localparam int CYC_T0H = cyc(CLK_HZ, T0H_NS);
    localparam int CYC_T1H = cyc(CLK_HZ, T1H_NS);
    localparam int CYC_RES = cyc_us(CLK_HZ, RES_US);
    localparam int TW      = $clog2(CYC_RES + 1);
    localparam int BW      = $clog2(BPP);

    localparam logic [TW-1:0] PER_LAST = TW'(CYC_PER - 1);
    localparam logic [TW-1:0] RES_LAST = TW'(CYC_RES - 1);
    localparam logic [TW-1:0] T0H_CYC  = TW'(CYC_T0H);
    localparam logic [TW-1:0] T1H_CYC  = TW'(CYC_T1H);
    localparam logic [BW-1:0] LAST_BIT = BW'(BPP - 1);

    // Refuse to elaborate with a pixel width or FIFO depth the design
    // cannot handle.
    if (!bpp_legal(BPP) || (FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || ((CLK_HZ % 1000000) != 0))
    begin : g_param_check
        $error("ws2812_stream: illegal parameter set");
    end

    seq_state_t     state, state_nx;
    logic [TW-1:0]  timer, timer_nx;
    logic [BW-1:0]  bit_idx, bit_nx;
    logic [BPP-1:0] shreg, sh_nx;
    logic           latch_flag, latch_nx;
    logic           power_on, power_on_nx;
    logic           first_cycle;
    logic           frame_done_nx, starved_nx, led_nx;

    logic           fifo_push, fifo_pop;
    logic [BPP:0]   fifo_rd;
    logic           fifo_empty, fifo_full;

    logic [TW-1:0]  high_thr;
    logic           bit_end, pixel_end;

    ws2812_fifo #(
        .WIDTH (BPP + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({latch_in, data_in}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .level     (level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // ready only looks at registered state, never at this cycle's pop, and
    // stays low for the first cycle after reset release.
    assign ready     = !fifo_full && !first_cycle;
    assign fifo_push = valid && ready;
    assign busy      = !((state == IDLE) && fifo_empty);

    assign high_thr  = shreg[BPP-1] ? T1H_CYC : T0H_CYC;
    assign bit_end   = (timer == PER_LAST);
    assign pixel_end = bit_end && (bit_idx == LAST_BIT);

    // Sequencer next-state. The last bit of a pixel either chains straight
    // into the next queued pixel (timer restarts at 0, no gap), enters the
    // latch low period, or falls back to IDLE and reports starvation.
    always_comb begin
        state_nx      = state;
        timer_nx      = timer;
        bit_nx        = bit_idx;
        sh_nx         = shreg;
        latch_nx      = latch_flag;
        power_on_nx   = power_on;
        fifo_pop      = 1'b0;
        frame_done_nx = 1'b0;
        starved_nx    = 1'b0;

        case (state)
            RST_LOW: begin
                if (timer == RES_LAST) begin
                    state_nx      = IDLE;
                    timer_nx      = '0;
                    frame_done_nx = !power_on;
                    power_on_nx   = 1'b0;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_nx = SEND;
                    timer_nx = '0;
                    bit_nx   = '0;
                    sh_nx    = fifo_rd[BPP-1:0];
                    latch_nx = fifo_rd[BPP];
                end
            end
            SEND: begin
                if (!bit_end) begin
                    timer_nx = timer + TW'(1);
                end else if (!pixel_end) begin
                    timer_nx = '0;
                    bit_nx   = bit_idx + BW'(1);
                    sh_nx    = {shreg[BPP-2:0], 1'b0};
                end else if (latch_flag) begin
                    state_nx = RST_LOW;
                    timer_nx = '0;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    timer_nx = '0;
                    bit_nx   = '0;
                    sh_nx    = fifo_rd[BPP-1:0];
                    latch_nx = fifo_rd[BPP];
                end else begin
                    state_nx   = IDLE;
                    timer_nx   = '0;
                    starved_nx = 1'b1;
                end
            end
            default: begin
                state_nx = RST_LOW;
                timer_nx = '0;
            end
        endcase
    end

    // led is registered from the current bit timer, so it trails the state
    // by one cycle: a pop at edge N+1 shows up as led high from edge N+2.
    assign led_nx = (state == SEND) && (timer < high_thr);

    // State and output registers. Reset aborts any pixel in flight and
    // restarts the power-on low period, which does not pulse frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RST_LOW;
            timer       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            latch_flag  <= 1'b0;
            power_on    <= 1'b1;
            first_cycle <= 1'b1;
            led         <= 1'b0;
            frame_done  <= 1'b0;
            starved     <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            bit_idx     <= bit_nx;
            shreg       <= sh_nx;
            latch_flag  <= latch_nx;
            power_on    <= power_on_nx;
            first_cycle <= 1'b0;
            led         <= led_nx;
            frame_done  <= frame_done_nx;
            starved     <= starved_nx;
        end
    end

endmodule

// File: tb/tb_ws2812_stream.sv
// ----------------------------------------------------------------------------
// tb_ws2812_stream
// Drives a 24-bit instance (dut_a) and a 32-bit instance (dut_b) of the
// streamer. The led line is decoded back into bits purely from pulse widths
// and bit periods, and compared with the pixels that were pushed.
// ----------------------------------------------------------------------------
module tb_ws2812_stream;

    localparam int CLK_HZ  = 20000000;
    localparam int CYC_PER = (CLK_HZ / 1000000) * 1250 / 1000;
    localparam int CYC_T0H = (CLK_HZ / 1000000) * 400 / 1000;
    localparam int CYC_T1H = (CLK_HZ / 1000000) * 800 / 1000;
    localparam int CYC_RES = (CLK_HZ / 1000000) * 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data_bus = '0;
    logic        latch_bus = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        ready_a, ready_b, busy_a, busy_b;
    logic        frame_done_a, frame_done_b, starved_a, starved_b, led_a, led_b;
    logic [2:0]  level_a, level_b;

    int checks = 0;
    int failures = 0;
    int fdCountA = 0, fdCountB = 0, stCountA = 0, stCountB = 0;

    logic [31:0] expQ[$];
    bit          rxBits[$];
    int          rxBadHigh, rxBadPeriod;

    ws2812_stream #(.BPP(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_bus[23:0]), .latch_in(latch_bus),
        .valid(valid_a), .ready(ready_a), .level(level_a), .busy(busy_a),
        .frame_done(frame_done_a), .starved(starved_a), .led(led_a)
    );

    ws2812_stream #(.BPP(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_bus), .latch_in(latch_bus),
        .valid(valid_b), .ready(ready_b), .level(level_b), .busy(busy_b),
        .frame_done(frame_done_b), .starved(starved_b), .led(led_b)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_done_a) fdCountA <= fdCountA + 1;
        if (frame_done_b) fdCountB <= fdCountB + 1;
        if (starved_a)    stCountA <= stCountA + 1;
        if (starved_b)    stCountB <= stCountB + 1;
    end

    function automatic logic getLed(input int sel);
        return (sel != 0) ? led_b : led_a;
    endfunction

    function automatic logic getReady(input int sel);
        return (sel != 0) ? ready_b : ready_a;
    endfunction

    function automatic logic getFrameDone(input int sel);
        return (sel != 0) ? frame_done_b : frame_done_a;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Push one pixel through the valid/ready handshake and record it.
    task automatic applyStimulus(input int sel, input logic [31:0] px, input logic lt);
        int w = 0;
        @(negedge clk);
        while (!getReady(sel) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (!getReady(sel)) begin
            checkOutput("push_ready_timeout", 32'(getReady(sel)), 32'd1);
            return;
        end
        data_bus  = px;
        latch_bus = lt;
        if (sel != 0) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        expQ.push_back(px);
    endtask

    // Decode nbits from the led line, starting at the current negedge.
    task automatic receiveStream(input int sel, input int nbits, input int timeout);
        int w = 0;
        int h, l;
        rxBits.delete();
        rxBadHigh   = 0;
        rxBadPeriod = 0;
        while (!getLed(sel) && w < timeout) begin
            @(negedge clk);
            w++;
        end
        if (!getLed(sel)) begin
            checkOutput("rx_start_led", 32'(getLed(sel)), 32'd1);
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            h = 0;
            while (getLed(sel) && h <= CYC_PER) begin
                h++;
                @(negedge clk);
            end
            if (h != CYC_T0H && h != CYC_T1H) rxBadHigh++;
            rxBits.push_back(2 * h > CYC_T0H + CYC_T1H);
            if (b < nbits - 1) begin
                l = 0;
                while (!getLed(sel) && l < CYC_PER) begin
                    l++;
                    @(negedge clk);
                end
                if (h + l != CYC_PER) rxBadPeriod++;
            end else begin
                for (int k = 0; k < CYC_PER - h; k++) begin
                    if (getLed(sel)) rxBadPeriod++;
                    @(negedge clk);
                end
            end
        end
    endtask

    // Latch low period, counted up to and including the frame_done cycle.
    task automatic measureLatch(input int sel);
        int n = 0;
        int ledHigh = 0;
        logic seen = 1'b0;
        while (!seen && n < 2 * CYC_RES) begin
            n++;
            if (getLed(sel)) ledHigh++;
            if (getFrameDone(sel)) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("latch_frame_done_seen", 32'(seen), 32'd1);
        checkOutput("latch_low_len", 32'(n), 32'(CYC_RES));
        checkOutput("latch_led_high_cycles", 32'(ledHigh), 32'd0);
        @(negedge clk);
        checkOutput("frame_done_width", 32'(getFrameDone(sel)), 32'd0);
    endtask

    function automatic logic [31:0] rxPixel(input int idx, input int bpp);
        logic [31:0] v = '0;
        for (int i = 0; i < bpp; i++) begin
            if (idx * bpp + i < rxBits.size())
                v = {v[30:0], rxBits[idx * bpp + i]};
            else
                v = {v[30:0], 1'b0};
        end
        return v;
    endfunction

    task automatic compareStream(input int npix, input int bpp);
        checkOutput("rx_high_widths_bad", 32'(rxBadHigh), 32'd0);
        checkOutput("rx_bit_periods_bad", 32'(rxBadPeriod), 32'd0);
        checkOutput("rx_bit_count", 32'(rxBits.size()), 32'(npix * bpp));
        for (int p = 0; p < npix; p++) begin
            checkOutput($sformatf("rx_pixel%0d", p), rxPixel(p, bpp),
                        (p < expQ.size()) ? expQ[p] : 32'hDEAD_BEEF);
        end
    endtask

    // Release reset and follow the power-on low period. With queueFour set,
    // four pixels are pushed from the second cycle on and the frame is
    // received once the low period ends.
    task automatic resetAndPowerOn(input bit queueFour);
        int fd0 = fdCountA;
        int ledOnes = 0;
        int last = queueFour ? CYC_RES + 2 : CYC_RES;
        expQ.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 checkOutput("ready_first_cycle", 32'(ready_a), 32'd0);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (queueFour && c <= 4) begin
                data_bus  = {8'h00, 24'($urandom())};
                latch_bus = (c == 4);
                valid_a   = 1'b1;
                expQ.push_back(data_bus);
            end
            if (c == 5) valid_a = 1'b0;
            if (c == 1) checkOutput("ready_second_cycle", 32'(ready_a), 32'd1);
            if (c <= CYC_RES + 1 && led_a) ledOnes++;
            if (queueFour && c == 5) begin
                checkOutput("level_full", 32'(level_a), 32'd4);
                checkOutput("ready_when_full", 32'(ready_a), 32'd0);
            end
            if (queueFour && c == CYC_RES + 1) begin
                checkOutput("level_after_pop", 32'(level_a), 32'd3);
                checkOutput("ready_after_pop", 32'(ready_a), 32'd1);
            end
            if (!queueFour && c == CYC_RES - 1) checkOutput("busy_power_on", 32'(busy_a), 32'd1);
            if (!queueFour && c == CYC_RES) checkOutput("busy_after_power_on", 32'(busy_a), 32'd0);
        end
        checkOutput("power_on_led_high_cycles", 32'(ledOnes), 32'd0);
        checkOutput("power_on_no_frame_done", 32'(fdCountA - fd0), 32'd0);
        if (queueFour) begin
            checkOutput("queued_first_rise", 32'(led_a), 32'd1);
            receiveStream(0, 4 * 24, 4);
            compareStream(4, 24);
            measureLatch(0);
        end
    endtask

    task automatic directedFrame(input int sel, input logic [31:0] px);
        int w = 0;
        int fd0 = (sel != 0) ? fdCountB : fdCountA;
        int bpp = (sel != 0) ? 32 : 24;
        expQ.delete();
        applyStimulus(sel, px, 1'b1);
        do begin
            @(negedge clk);
            w++;
        end while (!getLed(sel) && w < 10);
        checkOutput("pop_to_led_latency", 32'(w), 32'd3);
        receiveStream(sel, bpp, 4);
        compareStream(1, bpp);
        measureLatch(sel);
        checkOutput("frame_done_count", 32'((sel != 0) ? fdCountB - fd0 : fdCountA - fd0), 32'd1);
    endtask

    task automatic randomFrame(input int sel, input int npix);
        int bpp = (sel != 0) ? 32 : 24;
        int st0 = (sel != 0) ? stCountB : stCountA;
        expQ.delete();
        @(negedge clk);
        fork
            begin
                for (int p = 0; p < npix; p++) begin
                    logic [31:0] px;
                    px = $urandom();
                    if (bpp == 24) px[31:24] = 8'h00;
                    applyStimulus(sel, px, p == npix - 1);
                end
            end
            begin
                receiveStream(sel, npix * bpp, 200);
                measureLatch(sel);
            end
        join
        compareStream(npix, bpp);
        checkOutput("random_no_starve", 32'((sel != 0) ? stCountB - st0 : stCountA - st0), 32'd0);
    endtask

    initial begin
        int st0, fd0, w;

        $display("[TB] start");
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_led", 32'(led_a), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done_a), 32'd0);
        checkOutput("rst_starved", 32'(starved_a), 32'd0);
        checkOutput("rst_level", 32'(level_a), 32'd0);
        checkOutput("rst_ready", 32'(ready_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd1);
        checkOutput("rst_busy_b", 32'(busy_b), 32'd1);
        checkOutput("rst_level_b", 32'(level_b), 32'd0);
        repeat (3) @(negedge clk);
        resetAndPowerOn(1'b0);

        $display("[TB] single pixel A50000 with latch");
        directedFrame(0, 32'h00A5_0000);

        $display("[TB] starved pixel FFFFFF");
        expQ.delete();
        st0 = stCountA;
        fd0 = fdCountA;
        applyStimulus(0, 32'h00FF_FFFF, 1'b0);
        @(negedge clk);
        receiveStream(0, 24, 10);
        compareStream(1, 24);
        checkOutput("starved_count", 32'(stCountA - st0), 32'd1);
        checkOutput("starved_led", 32'(led_a), 32'd0);
        checkOutput("starved_busy", 32'(busy_a), 32'd0);
        checkOutput("starved_no_frame_done", 32'(fdCountA - fd0), 32'd0);

        $display("[TB] 32-bit pixel 000000FF with latch");
        directedFrame(1, 32'h0000_00FF);

        $display("[TB] random frames");
        for (int f = 0; f < 2; f++) randomFrame(0, int'($urandom_range(1, 5)));
        randomFrame(1, int'($urandom_range(1, 3)));

        $display("[TB] reset mid-bit with queued pixels");
        for (int p = 0; p < 4; p++) applyStimulus(0, {8'h00, 24'($urandom())}, 1'b0);
        checkOutput("level_before_abort", 32'(level_a), 32'd3);
        w = 0;
        while (!led_a && w < 10) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        checkOutput("led_high_before_abort", 32'(led_a), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("abort_led", 32'(led_a), 32'd0);
        checkOutput("abort_level", 32'(level_a), 32'd0);
        checkOutput("abort_ready", 32'(ready_a), 32'd0);
        checkOutput("abort_busy", 32'(busy_a), 32'd1);
        repeat (3) @(negedge clk);
        resetAndPowerOn(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
